vote_tally_reader: RTL and testbench
====================================

VOTE_TALLY_READER -- requirements
Module: vote_tally_reader

Interface
REQ-001 Parameter SETTLE, default 4: number of cycles a result-mode button is held before `led_i` is sampled (minimum 2).
REQ-002 Parameter GAP, default 2: number of idle cycles with all buttons low between candidates (minimum 1).
REQ-003 `clk`  in  1  single clock; all state changes on the rising edge.
REQ-004 `reset`  in  1  asynchronous, active-low reset.
REQ-005 `start`  in  1  level-sampled request to begin one result scan.
REQ-006 `led_i`  in  8  count displayed by the voting machine for the currently pressed candidate.
REQ-007 `mode_o`  out  1  drives the voting machine's mode input; 1 selects result mode.
REQ-008 `button1`..`button4`  out  1 each  drive the voting machine's candidate buttons; at most one is high at a time.
REQ-009 `busy`  out  1  high while a scan is in progress.
REQ-010 `done`  out  1  single-cycle pulse when the results are valid.
REQ-011 `winner`  out  2  index (0..3) of the candidate with the most votes.
REQ-012 `winner_votes`  out  8  vote count of the winning candidate.
REQ-013 `tie`  out  1  high when two or more candidates share the maximum count.
REQ-014 `total`  out  10  sum of the four counts.
REQ-015 `count_sel`  in  2 / `count_out`  out  8  combinational readback of the stored count for candidate `count_sel`.

Function
REQ-016 The FSM SHALL use the states IDLE, ARM, PRESS, GAP, EVAL and DONE.
REQ-017 IDLE: all outputs are held and `mode_o` is 0; when `start` is 1 at a clock edge, the FSM SHALL go to ARM, clear the candidate index and set `busy`.
REQ-018 ARM (1 cycle): `mode_o`=1 with all buttons 0, so that mode is set up before any button is pressed; the FSM then goes to PRESS.
REQ-019 PRESS (SETTLE cycles): `mode_o`=1 and only `button[idx+1]`=1; on the last PRESS cycle `led_i` SHALL be captured into `count[idx]`, then the FSM goes to GAP.
REQ-020 GAP (GAP cycles): `mode_o`=1 and all buttons 0; the FSM then goes to PRESS with idx+1, or to EVAL if idx=3.
REQ-021 EVAL (1 cycle): the FSM computes `winner`, `winner_votes`, `tie` and `total` from the four stored counts and registers them at the end of the cycle.
REQ-022 DONE (1 cycle): `done`=1, `busy`=0 and `mode_o`=0; the FSM then returns to IDLE.
REQ-023 `done` SHALL assert exactly 2+4*(SETTLE+GAP) cycles after the edge at which `start` was sampled (26 cycles at the defaults).
REQ-024 `mode_o` SHALL be 1 continuously from ARM through EVAL, so that no button pulse can ever be counted as a vote.
REQ-025 `start` SHALL be ignored while `busy`=1; a `start` held high through DONE begins a new scan from IDLE on the following edge.
REQ-026 Ties resolve to the lowest index; `tie`=1 whenever the maximum count is shared.
REQ-027 All counts zero: `winner`=0, `winner_votes`=0, `tie`=1, `total`=0.
REQ-028 `total` is a 10-bit unsigned sum with no overflow (maximum 1020); counts are unsigned 8-bit values.
REQ-029 Result outputs SHALL hold their last values until the next EVAL and SHALL NOT change during a scan.

Reset
REQ-030 While `reset`=0 the block SHALL asynchronously force: state IDLE; `mode_o`, buttons, `busy` and `done` to 0; all stored counts, `winner`, `winner_votes` and `total` to 0; and `tie` to 0.
REQ-031 A reset asserted mid-scan SHALL abort the scan immediately, with all buttons and `mode_o` low on the same edge, and no `done` pulse.
REQ-032 After reset deasserts, the block waits in IDLE for `start`.

Structure
REQ-033 The shared package SHALL hold: the state enum, the candidate count constant (4), the count width (8) and the total width (10).
REQ-034 One sub-module, `tally_max4`, SHALL be combinational: four counts in; winner, maximum count, tie flag and total out; it is used in EVAL.
REQ-035 The timer SHALL be a single down-counter sized for max(SETTLE, GAP), reloaded on each state entry.

Verification
REQ-036 Counts (3,7,2,1) and start -> `winner`=1, `winner_votes`=7, `tie`=0, `total`=13, `done` at cycle 26.
REQ-037 Counts (3,7,7,1) -> `winner`=1, `tie`=1, `total`=18.
REQ-038 Counts (255,255,255,255) -> `total`=1020, `winner`=0, `tie`=1.
REQ-039 Counts all 0 -> `winner`=0, `winner_votes`=0, `tie`=1, `total`=0.
REQ-040 Reset pulsed during the PRESS of candidate 2 -> buttons and `mode_o` go to 0 asynchronously, no `done`, all results 0; the next scan completes normally.
REQ-041 Checker across all runs: never more than one button high; any button high implies `mode_o`=1 on that cycle and the preceding cycle; `start` pulsed during `busy` has no effect.

Source files
------------

// File: rtl/vote_tally_reader_pkg.sv
// Shared types and constants for the vote tally reader.
package vote_tally_reader_pkg;

    localparam int unsigned NumCand = 4;
    localparam int unsigned CountW  = 8;
    localparam int unsigned TotalW  = 10;

    typedef enum logic [2:0] {
        StIdle,
        StArm,
        StPress,
        StGap,
        StEval,
        StDone
    } state_t;

    // One-hot button pattern for a candidate index.
    function automatic logic [NumCand-1:0] cand_onehot(input logic [1:0] idx);
        return NumCand'(1) << idx;
    endfunction

endpackage

// File: rtl/vote_tally_reader_if.sv
// Signal bundle between the tally reader and its host / voting machine.
interface vote_tally_reader_if;
    import vote_tally_reader_pkg::*;

    logic              start;
    logic [CountW-1:0] led_i;
    logic              mode_o;
    logic              button1;
    logic              button2;
    logic              button3;
    logic              button4;
    logic              busy;
    logic              done;
    logic [1:0]        winner;
    logic [CountW-1:0] winner_votes;
    logic              tie;
    logic [TotalW-1:0] total;
    logic [1:0]        count_sel;
    logic [CountW-1:0] count_out;

    modport master (
        output start, led_i, count_sel,
        input  mode_o, button1, button2, button3, button4, busy, done,
        input  winner, winner_votes, tie, total, count_out
    );

    modport slave (
        input  start, led_i, count_sel,
        output mode_o, button1, button2, button3, button4, busy, done,
        output winner, winner_votes, tie, total, count_out
    );

endinterface

// File: rtl/vote_tally_reader_tally_max4.sv
// Combinational winner / tie / total over four candidate counts.
module tally_max4
    import vote_tally_reader_pkg::*;
(
    input  logic [NumCand-1:0][CountW-1:0] counts,
    output logic [1:0]                     winner,
    output logic [CountW-1:0]              max_count,
    output logic                           tie,
    output logic [TotalW-1:0]              total
);

    int unsigned n_max;

    // Strict '>' keeps the lowest index on equal counts.
    always_comb begin
        winner    = 2'd0;
        max_count = counts[0];
        total     = '0;
        n_max     = 0;
        for (int i = 1; i < NumCand; i++) begin
            if (counts[i] > max_count) begin
                max_count = counts[i];
                winner    = 2'(i);
            end
        end
        for (int i = 0; i < NumCand; i++) begin
            total = total + TotalW'(counts[i]);
            if (counts[i] == max_count) n_max = n_max + 1;
        end
        tie = (n_max > 1);
    end

endmodule

// File: rtl/vote_tally_reader.sv
// Scans the four candidate counts of a voting machine in result mode and
// reports winner, tie and total.
module vote_tally_reader
    import vote_tally_reader_pkg::*;
#(
    parameter int unsigned SETTLE = 4,
    parameter int unsigned GAP    = 2
) (
    input logic               clk,
    input logic               reset,
    vote_tally_reader_if.slave bus
);

    localparam int unsigned TimerMax = (SETTLE > GAP) ? SETTLE : GAP;
    localparam int unsigned TimerW   = $clog2(TimerMax);

    state_t                         state_q;
    logic [TimerW-1:0]              timer_q;
    logic [1:0]                     idx_q;
    logic [NumCand-1:0]             buttons_q;
    logic                           mode_q;
    logic                           busy_q;
    logic                           done_q;
    logic [NumCand-1:0][CountW-1:0] counts_q;
    logic [1:0]                     winner_q;
    logic [CountW-1:0]              winner_votes_q;
    logic                           tie_q;
    logic [TotalW-1:0]              total_q;

    logic [1:0]        eval_winner;
    logic [CountW-1:0] eval_max;
    logic              eval_tie;
    logic [TotalW-1:0] eval_total;

    tally_max4 u_tally (
        .counts    (counts_q),
        .winner    (eval_winner),
        .max_count (eval_max),
        .tie       (eval_tie),
        .total     (eval_total)
    );

    // Scan FSM; every output is registered so mode/buttons never glitch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            timer_q        <= '0;
            idx_q          <= 2'd0;
            buttons_q      <= '0;
            mode_q         <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            counts_q       <= '0;
            winner_q       <= 2'd0;
            winner_votes_q <= '0;
            tie_q          <= 1'b0;
            total_q        <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        state_q <= StArm;
                        idx_q   <= 2'd0;
                        busy_q  <= 1'b1;
                        mode_q  <= 1'b1;
                    end
                end
                StArm: begin
                    state_q   <= StPress;
                    timer_q   <= TimerW'(SETTLE - 1);
                    buttons_q <= cand_onehot(idx_q);
                end
                StPress: begin
                    if (timer_q == '0) begin
                        counts_q[idx_q] <= bus.led_i;
                        buttons_q       <= '0;
                        timer_q         <= TimerW'(GAP - 1);
                        state_q         <= StGap;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                StGap: begin
                    if (timer_q != '0) begin
                        timer_q <= timer_q - 1'b1;
                    end else if (idx_q == 2'd3) begin
                        state_q <= StEval;
                    end else begin
                        idx_q     <= idx_q + 2'd1;
                        buttons_q <= cand_onehot(idx_q + 2'd1);
                        timer_q   <= TimerW'(SETTLE - 1);
                        state_q   <= StPress;
                    end
                end
                StEval: begin
                    winner_q       <= eval_winner;
                    winner_votes_q <= eval_max;
                    tie_q          <= eval_tie;
                    total_q        <= eval_total;
                    mode_q         <= 1'b0;
                    busy_q         <= 1'b0;
                    done_q         <= 1'b1;
                    state_q        <= StDone;
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Drive the bundle from the registered state.
    always_comb begin
        bus.mode_o       = mode_q;
        bus.button1      = buttons_q[0];
        bus.button2      = buttons_q[1];
        bus.button3      = buttons_q[2];
        bus.button4      = buttons_q[3];
        bus.busy         = busy_q;
        bus.done         = done_q;
        bus.winner       = winner_q;
        bus.winner_votes = winner_votes_q;
        bus.tie          = tie_q;
        bus.total        = total_q;
        bus.count_out    = counts_q[bus.count_sel];
    end

endmodule

// File: tb/tb_vote_tally_reader.sv
// Randomised scoreboard bench for vote_tally_reader with a voting-machine model.
module tb_vote_tally_reader;

    localparam int unsigned SETTLE = 4;
    localparam int unsigned GAP    = 2;
    localparam int          LAT    = 2 + 4 * (SETTLE + GAP);

    typedef struct {
        int winner;
        int votes;
        int tie;
        int total;
        int due;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    vote_tally_reader_if bus ();

    vote_tally_reader #(
        .SETTLE (SETTLE),
        .GAP    (GAP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t       sbq[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    int         held   = 0;
    logic [7:0] votes[4];
    int         hold_w = 0, hold_v = 0, hold_t = 0, hold_tot = 0;
    logic       prev_mode = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: highest count wins, first such index on ties.
    function automatic exp_t model(input int v0, input int v1, input int v2, input int v3);
        exp_t e;
        int   a[4];
        int   mx;
        int   n;
        a = '{v0, v1, v2, v3};
        mx = 0;
        foreach (a[i]) if (a[i] > mx) mx = a[i];
        e.winner = -1;
        n = 0;
        e.total = 0;
        foreach (a[i]) begin
            e.total += a[i];
            if (a[i] == mx) begin
                n++;
                if (e.winner < 0) e.winner = i;
            end
        end
        e.votes = mx;
        e.tie   = (n > 1) ? 1 : 0;
        e.due   = 0;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Voting machine: shows the true count only once a button has settled.
    always @(posedge clk) begin
        if (bus.button1 | bus.button2 | bus.button3 | bus.button4) held <= held + 1;
        else held <= 0;
    end

    always_comb begin
        int sel;
        sel = -1;
        if (bus.button1) sel = 0;
        if (bus.button2) sel = 1;
        if (bus.button3) sel = 2;
        if (bus.button4) sel = 3;
        bus.led_i = 8'h5A;
        if (sel >= 0) bus.led_i = (held >= int'(SETTLE) - 1) ? votes[sel] : ~votes[sel];
    end

    // Monitor: pops the scoreboard on done and checks protocol every cycle.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            if (bus.done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("latency", cyc, e.due);
                    chk("winner", int'(bus.winner), e.winner);
                    chk("winner_votes", int'(bus.winner_votes), e.votes);
                    chk("tie", int'(bus.tie), e.tie);
                    chk("total", int'(bus.total), e.total);
                    chk("done_busy", int'(bus.busy), 0);
                    chk("done_mode", int'(bus.mode_o), 0);
                    hold_w = e.winner; hold_v = e.votes; hold_t = e.tie; hold_tot = e.total;
                end
            end else if (bus.busy) begin
                if (bus.winner !== 2'(hold_w) || bus.winner_votes !== 8'(hold_v) ||
                    bus.tie !== 1'(hold_t) || bus.total !== 10'(hold_tot))
                    chk("results_held", 0, 1);
            end
            if ($countones({bus.button1, bus.button2, bus.button3, bus.button4}) > 1)
                chk("one_button", 0, 1);
            if (bus.button1 | bus.button2 | bus.button3 | bus.button4) begin
                if (!(bus.mode_o && prev_mode)) chk("button_mode", 0, 1);
            end
        end
        prev_mode = bus.mode_o;
    end

    task automatic wait_drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0) begin
            chk("timeout", sbq.size(), 0);
            sbq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic readback();
        for (int i = 0; i < 4; i++) begin
            bus.count_sel = 2'(i);
            #1;
            chk("count_out", int'(bus.count_out), int'(votes[i]));
        end
    endtask

    task automatic run_scan(input int v0, input int v1, input int v2, input int v3,
                            input bit poke);
        exp_t e;
        votes = '{8'(v0), 8'(v1), 8'(v2), 8'(v3)};
        e = model(v0, v1, v2, v3);
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        e.due = cyc + LAT;
        sbq.push_back(e);
        if (poke) begin
            repeat ($urandom_range(1, 20)) @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        wait_drain();
        readback();
    endtask

    int s;
    exp_t e1, e2;

    initial begin
        bus.start     = 1'b0;
        bus.count_sel = 2'd0;
        votes = '{8'd0, 8'd0, 8'd0, 8'd0};
        #12;
        chk("rst_mode", int'(bus.mode_o), 0);
        chk("rst_buttons", int'({bus.button1, bus.button2, bus.button3, bus.button4}), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_total", int'(bus.total), 0);
        chk("rst_tie", int'(bus.tie), 0);
        chk("rst_winner_votes", int'(bus.winner_votes), 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        run_scan(3, 7, 2, 1, 1'b0);
        run_scan(3, 7, 7, 1, 1'b0);
        run_scan(255, 255, 255, 255, 1'b0);
        run_scan(0, 0, 0, 0, 1'b0);

        for (int k = 0; k < 10; k++) begin
            if (k % 3 == 0)
                run_scan($urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
            else
                run_scan($urandom_range(0, 255), $urandom_range(0, 255),
                         $urandom_range(0, 255), $urandom_range(0, 255), k[0]);
        end

        // start held high through DONE: a second scan follows after IDLE.
        votes = '{8'd9, 8'd4, 8'd9, 8'd200};
        e1 = model(9, 4, 9, 200);
        e2 = e1;
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        s = cyc;
        e1.due = s + LAT;
        e2.due = s + LAT + 2 + LAT;
        sbq.push_back(e1);
        sbq.push_back(e2);
        while (cyc < s + LAT + 3) @(negedge clk);
        bus.start = 1'b0;
        wait_drain();
        readback();

        // Reset in the middle of candidate 2's press aborts the scan.
        votes = '{8'd11, 8'd22, 8'd33, 8'd44};
        @(negedge clk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        s = 0;
        while (!bus.button3 && s < 100) begin
            @(negedge clk);
            s++;
        end
        chk("reach_press2", int'(bus.button3), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_buttons", int'({bus.button1, bus.button2, bus.button3, bus.button4}), 0);
        chk("arst_mode", int'(bus.mode_o), 0);
        chk("arst_busy", int'(bus.busy), 0);
        chk("arst_done", int'(bus.done), 0);
        chk("arst_winner", int'(bus.winner), 0);
        chk("arst_winner_votes", int'(bus.winner_votes), 0);
        chk("arst_total", int'(bus.total), 0);
        chk("arst_tie", int'(bus.tie), 0);
        for (int i = 0; i < 4; i++) begin
            bus.count_sel = 2'(i);
            #1;
            chk("arst_count", int'(bus.count_out), 0);
        end
        hold_w = 0; hold_v = 0; hold_t = 0; hold_tot = 0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("idle_after_reset", int'(bus.busy), 0);

        run_scan(5, 1, 8, 8, 1'b0);
        run_scan($urandom_range(0, 255), $urandom_range(0, 255),
                 $urandom_range(0, 255), $urandom_range(0, 255), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
